// File: rtl/fb_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// fb_stream_reader_pkg
// Definitions shared by the frame-buffer read path: FSM state encodings and
// the layout of the per-pixel flag field carried alongside each pixel through
// the skid FIFO. A FIFO word is {pixel, flags}, and the flag bits sit at
// FLAG_SOF / FLAG_EOL / FLAG_EOF.
// ---------------------------------------------------------------------------
package fb_stream_reader_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_READ  = 2'd1;
    localparam fsm_state_t ST_DRAIN = 2'd2;
    localparam fsm_state_t ST_DONE  = 2'd3;

    localparam int FLAG_W   = 3;
    localparam int FLAG_SOF = 2;
    localparam int FLAG_EOL = 1;
    localparam int FLAG_EOF = 0;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic sof,
                                                     input logic eol,
                                                     input logic eof);
        logic [FLAG_W-1:0] f;
        f           = '0;
        f[FLAG_SOF] = sof;
        f[FLAG_EOL] = eol;
        f[FLAG_EOF] = eof;
        return f;
    endfunction

endpackage

// File: rtl/fb_stream_reader_skid.sv
// ---------------------------------------------------------------------------
// fb_stream_reader_skid
// Two-entry FIFO that holds RAM words (pixel + flags) until the consumer
// takes them. The head is a registered entry: a word pushed in one cycle is
// visible at the head from the next cycle on (there is no bypass path).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_push      write i_din this cycle
//   i_pop       drop the head entry this cycle
//   i_din       word to store
//   o_head      oldest stored word (not meaningful while o_empty)
//   o_full      two entries stored
//   o_empty     nothing stored
// Pushing and popping together while full is accepted: the popped head is
// read before the edge that overwrites its slot.
// ---------------------------------------------------------------------------
module fb_stream_reader_skid #(
    parameter int Width = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [Width-1:0] i_din,
    output logic [Width-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    logic [Width-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_head    = r_mem[r_rptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop_ok) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

endmodule

// File: rtl/fb_stream_reader.sv
// ---------------------------------------------------------------------------
// fb_stream_reader
// Read side of the frame buffer. After start, walks the stored frame in
// raster order through a synchronous RAM read port and emits the pixels as a
// valid/ready stream tagged with start-of-frame, end-of-line and end-of-frame.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse: frame committed, begin readout
//   busy              frame readout in progress
//   rd_en, rd_addr    RAM read request
//   rd_data           RAM data, one cycle after rd_en
//   out_data          stream pixel
//   out_valid         stream valid; out_ready: consumer ready
//   out_sof/eol/eof   flags qualifying the current pixel
//   frame_done        one-cycle pulse after the last pixel has been taken
// Build option: define FB_RD_MIRROR_EN to read each line right-to-left
// (horizontal mirror); flags still follow the emitted order.
// ---------------------------------------------------------------------------
module fb_stream_reader
    import fb_stream_reader_pkg::*;
#(
    parameter int DataDepth = 4,
    parameter int ImageW    = 8,
    parameter int ImageH    = 8,
    parameter int AddrW     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 rd_en,
    output logic [AddrW-1:0]     rd_addr,
    input  logic [DataDepth-1:0] rd_data,
    output logic [DataDepth-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 frame_done
);

    localparam int XW    = $clog2(ImageW);
    localparam int YW    = $clog2(ImageH);
    localparam int WordW = DataDepth + FLAG_W;

    fsm_state_t        r_state;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_inflight;
    logic [FLAG_W-1:0] r_inflight_flags;

    logic              w_pop;
    logic              w_room;
    logic              w_issue;
    logic              w_eol;
    logic              w_last;
    logic [XW-1:0]     w_col;
    logic [FLAG_W-1:0] w_issue_flags;
    logic [WordW-1:0]  w_head;
    logic              w_full;
    logic              w_empty;

    assign w_eol         = (r_x == XW'(ImageW - 1));
    assign w_last        = w_eol && (r_y == YW'(ImageH - 1));
    // Flags are attached to the read in emitted order, so mirroring the
    // column only changes the address, never the flag positions.
    assign w_issue_flags = pack_flags((r_x == '0) && (r_y == '0), w_eol, w_last);

`ifdef FB_RD_MIRROR_EN
    assign w_col = XW'(ImageW - 1) - r_x;
`else
    assign w_col = r_x;
`endif

    assign w_pop = out_valid && out_ready;

    // A read may be issued only if its word is guaranteed a FIFO slot when it
    // returns next cycle: occupancy + in-flight - pop_now < 2. Counting the
    // pop of this cycle is what allows one pixel per clock.
    always_comb begin
        w_room = 1'b1;
        if (w_full) begin
            w_room = w_pop && !r_inflight;
        end else if (!w_empty) begin
            w_room = !r_inflight || w_pop;
        end
    end

    // The first read goes out in the start cycle itself: the FIFO is always
    // empty in IDLE, so no room check is needed there.
    always_comb begin
        w_issue = 1'b0;
        case (r_state)
            ST_IDLE: w_issue = start;
            ST_READ: w_issue = w_room;
            default: w_issue = 1'b0;
        endcase
    end

    assign rd_en   = w_issue;
    assign rd_addr = w_issue ? AddrW'(32'(r_y) * 32'(ImageW) + 32'(w_col)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_x              <= '0;
            r_y              <= '0;
            r_inflight       <= 1'b0;
            r_inflight_flags <= '0;
        end else begin
            r_inflight       <= w_issue;
            r_inflight_flags <= w_issue_flags;
            if (w_issue) begin
                if (w_eol) begin
                    r_x <= '0;
                    r_y <= w_last ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
            case (r_state)
                ST_IDLE:  if (start) r_state <= ST_READ;
                ST_READ:  if (w_issue && w_last) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_pop && out_eof) r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    fb_stream_reader_skid #(
        .Width (WordW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_din   ({rd_data, r_inflight_flags}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Outputs are forced to zero while the FIFO is empty so stale entries
    // never show up on the stream.
    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? '0 : w_head[WordW-1:FLAG_W];
    assign out_sof    = !w_empty && w_head[FLAG_SOF];
    assign out_eol    = !w_empty && w_head[FLAG_EOL];
    assign out_eof    = !w_empty && w_head[FLAG_EOF];
    assign busy       = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_fb_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fb_stream_reader
// Self-checking bench for fb_stream_reader. A behavioural RAM answers read
// requests; the expected pixel stream of a frame is computed from the frame
// geometry and RAM contents, and every handshaken pixel is compared with it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fb_stream_reader;

    localparam int DW = 4;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 6;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof, out_eol, out_eof;
    logic          frame_done;

    fb_stream_reader #(
        .DataDepth (DW),
        .ImageW    (W),
        .ImageH    (H),
        .AddrW     (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {15'd0, busy, rd_en, rd_addr, out_valid, out_data,
                out_sof, out_eol, out_eof, frame_done};
    endfunction

    // Expected frame, derived from geometry and RAM contents.
    logic [AW-1:0] exp_addr  [N];
    logic [DW-1:0] exp_data  [N];
    logic [2:0]    exp_flags [N];

    task automatic build_expected();
        for (int i = 0; i < N; i++) begin
            int x, y, a;
            x = i % W;
            y = i / W;
`ifdef FB_RD_MIRROR_EN
            a = y * W + (W - 1 - x);
`else
            a = y * W + x;
`endif
            exp_addr[i]  = AW'(a);
            exp_data[i]  = mem[a];
            exp_flags[i] = {i == 0, x == W - 1, i == N - 1};
        end
    endtask

    // Stream monitor state.
    bit         mon_en    = 1'b0;
    bit         time_chk  = 1'b0;
    bit         hold_pend = 1'b0;
    bit         prev_rd   = 1'b0;
    logic [7:0] hold_val  = '0;
    int         beat = 0, reads = 0, done_cnt = 0, done_cyc = 0, t0 = 0, max_occ = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            int occ;
            occ = reads - int'(prev_rd) - beat;
            if (occ > max_occ) max_occ = occ;
            if (rd_en) begin
                if (reads < N) check("rd_addr", 32'(rd_addr), 32'(exp_addr[reads]));
                else           check("extra_read", reads + 1, N);
                reads++;
            end
            if (hold_pend)
                check("hold_stable", {24'd0, out_valid, out_data, out_sof, out_eol, out_eof}, {24'd0, hold_val});
            hold_pend = out_valid && !out_ready;
            hold_val  = {1'b1, out_data, out_sof, out_eol, out_eof};
            if (out_valid && out_ready) begin
                if (beat < N) begin
                    check("beat_data", 32'(out_data), 32'(exp_data[beat]));
                    check("beat_flags", {29'd0, out_sof, out_eol, out_eof}, {29'd0, exp_flags[beat]});
                    if (beat == 0) check("busy_first", 32'(busy), 1);
                    if (time_chk) check("beat_cycle", cyc - t0, beat + 2);
                end else begin
                    check("extra_beat", beat + 1, N);
                end
                beat++;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_busy", 32'(busy), 0);
                check("done_after_eof", beat, N);
            end
            prev_rd = rd_en;
        end
    end

    int frame_no = 0;

    // rdy_mode: 0 ready always, 1 random 50%, 2 low for 10 cycles then high.
    // action:   0 none, 1 extra start at beat 30, 2 reset at beat 40.
    task automatic run_frame(input int rdy_mode, input int action, input bit chk_time);
        int  n_cyc;
        bit  restarted, rst_hit;
        build_expected();
        beat = 0; reads = 0; done_cnt = 0; max_occ = 0;
        hold_pend = 0; prev_rd = 0; time_chk = chk_time;
        n_cyc = 0; restarted = 0; rst_hit = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        t0        = cyc;
        mon_en    = 1'b1;
        while (done_cnt == 0 && n_cyc < 400 && !rst_hit) begin
            @(posedge clk); #1;
            n_cyc++;
            start = 1'b0;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (n_cyc >= 10);
            endcase
            if (rdy_mode == 2 && n_cyc == 10) check("stall_reads", reads, 2);
            if (action == 1 && beat >= 30 && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (action == 2 && beat >= 40) begin
                rst_n = 1'b0;
                mon_en = 1'b0;
                hold_pend = 1'b0;
                rst_hit = 1'b1;
                #1;
                check("rst_outputs", outs_vec(), 0);
                check("rst_beat", beat, 40);
            end
        end
        frame_no++;
        if (rst_hit) begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            $display("frame %0d: reset at beat %0d, reads=%0d", frame_no, beat, reads);
            return;
        end
        check("done_seen", done_cnt, 1);
        check("beats", beat, N);
        if (chk_time) check("done_cycle", done_cyc - t0, N + 2);
        check("fifo_occ_le2", 32'(max_occ <= 2), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            check("idle_after", {29'd0, busy, out_valid, rd_en}, 0);
        end
        check("no_extra_reads", reads, N);
        check("single_done", done_cnt, 1);
        mon_en = 1'b0;
        $display("frame %0d: mode=%0d action=%0d beats=%0d reads=%0d done_at=+%0d",
                 frame_no, rdy_mode, action, beat, reads, done_cyc - t0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        for (int a = 0; a < 2**AW; a++) mem[a] = DW'(a % 16);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_outputs", outs_vec(), 0);
        end

        run_frame(0, 0, 1);   // ramp, ready held high, exact timing
        run_frame(1, 0, 0);   // ramp, random ready
        run_frame(2, 0, 0);   // ramp, consumer stalled right after start
        run_frame(0, 1, 1);   // second start mid-frame is ignored
        run_frame(0, 2, 0);   // reset mid-frame

        // After reset nothing moves until a new start.
        beat = 0; reads = 0; done_cnt = 0; prev_rd = 0; hold_pend = 0; time_chk = 0;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_reads", reads, 0);
        check("post_rst_beats", beat, 0);
        mon_en = 1'b0;
        run_frame(0, 0, 1);   // fresh frame from address 0

        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < 2**AW; a++) mem[a] = DW'($urandom_range(0, 15));
            run_frame(1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
